teatris_varredura_matriz: RTL and testbench
===========================================

TEATRIS_VARREDURA_MATRIZ -- requirements
Module: teatris_varredura_matriz

Interface
REQ-001 SHALL have parameter DIVISOR, default 1000, meaning clock cycles each row stays lit (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port habilita, input, 1 bit: display enable.
REQ-005 SHALL have port selecao, input, 4 bits: requested pattern number (0-15).
REQ-006 SHALL have port endereco, output, 4 bits, registered: address driven to the pattern ROM.
REQ-007 SHALL have port padrao, input, 64 bits: ROM data, valid one clock after endereco changes; bits [63:56] = row 0 … [7:0] = row 7; bit 7 of a row = column 0.
REQ-008 SHALL have port linha, output, 8 bits, registered: one-hot active-high row select; linha[0] = row 0.
REQ-009 SHALL have port coluna, output, 8 bits, registered: active-high column data for the lit row.
REQ-010 SHALL have port quadro_fim, output, 1 bit, registered: one-cycle pulse at the end of each complete 8-row scan.

Function
REQ-011 SHALL implement FSM states BUSCA, ESPERA, CAPTURA and VARRE.
REQ-012 BUSCA behaviour:
- endereco <= selecao;
- linha = 0;
- advance to ESPERA only when habilita=1, otherwise hold.
REQ-013 ESPERA SHALL last exactly one cycle (ROM latency), then go to CAPTURA.
REQ-014 CAPTURA SHALL copy padrao into an internal 64-bit frame buffer, clear the row index and dwell counter, then go to VARRE.
REQ-015 VARRE behaviour:
- linha = one-hot(row index);
- coluna = buffer byte for that row;
- row held for exactly DIVISOR cycles, then row index increments.
REQ-016 After row 7 completes, quadro_fim SHALL pulse high for exactly one cycle and the FSM SHALL return to BUSCA; the pattern is re-fetched every frame.
REQ-017 Changes on selecao or padrao during VARRE SHALL NOT affect the current frame; they take effect on the next fetch.
REQ-018 When habilita=0 in VARRE, the block SHALL:
- force linha=0 and coluna=0 on the next cycle;
- return to BUSCA without asserting quadro_fim.
REQ-019 Dwell counter width SHALL be 16 bits and counts 0..DIVISOR-1; the row index SHALL be 3 bits and never wraps inside VARRE.
REQ-020 Frame period with habilita held at 1 SHALL be 3 + 8*DIVISOR cycles (BUSCA+ESPERA+CAPTURA, plus scan time).

Reset
REQ-021 While reset=1 at a clock edge, the block SHALL set:
- state = BUSCA;
- endereco = 0;
- linha = 0, coluna = 0, quadro_fim = 0;
- frame buffer = 0;
- row index = 0, dwell counter = 0.
REQ-022 Reset SHALL have priority over habilita and all FSM transitions, including mid-scan.
REQ-023 The first fetch after reset release SHALL use the selecao value present in the first BUSCA cycle.

Configuration
REQ-024 With macro TEATRIS_BLANK_EN defined:
- one blanking cycle (linha=0, coluna=0) SHALL be inserted before each row's dwell;
- frame period becomes 3 + 8*(DIVISOR+1) cycles.
REQ-025 Without TEATRIS_BLANK_EN, rows SHALL switch with no blanking cycle, as in REQ-015.

Verification
REQ-026 Reset/outputs: assert reset for 3 cycles mid-scan with DIVISOR=4 -> the cycle after reset, linha=0, coluna=0, endereco=0 and quadro_fim=0.
REQ-027 Row sequence: DIVISOR=4, selecao=15, ROM model returning 64'h08_5C_FE_0F_FF_0F_BF_0F -> expected response:
- linha = 01, 02, 04 … 80, each for 4 cycles;
- coluna = 08, 5C, FE, 0F, FF, 0F, BF, 0F;
- quadro_fim high exactly once, 35 cycles after the first BUSCA.
REQ-028 Latency: change selecao from 3 to 7 mid-frame -> endereco becomes 7 only in the next BUSCA; new coluna data appears 3 cycles later.
REQ-029 Enable: drop habilita during row 5 -> linha=0 on the next cycle, no quadro_fim, FSM holds in BUSCA; raising habilita restarts at row 0.
REQ-030 Blanking: with TEATRIS_BLANK_EN and DIVISOR=4 -> one linha=0 cycle precedes each row; the quadro_fim interval is 43 cycles.

Source files
------------

// File: rtl/teatris_varredura_matriz.sv
// LED matrix row scanner: fetches an 8x8 pattern from an external ROM,
// latches it into a frame buffer and lights one row at a time for DIVISOR
// cycles each, pulsing quadro_fim after every complete 8-row scan.
// Optional macro TEATRIS_BLANK_EN inserts one dark cycle before each row.
module teatris_varredura_matriz #(
  parameter int unsigned DIVISOR = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic [3:0]  selecao,
  output logic [3:0]  endereco,
  input  logic [63:0] padrao,
  output logic [7:0]  linha,
  output logic [7:0]  coluna,
  output logic        quadro_fim
);

  typedef enum logic [1:0] {BUSCA, ESPERA, CAPTURA, VARRE} state_t;

  localparam logic [15:0] ULTIMO = 16'(DIVISOR - 1);

  state_t      state, state_n;
  logic [63:0] quadro, quadro_n;
  logic [2:0]  indice, indice_n;
  logic [2:0]  proxima;
  logic [15:0] contador, contador_n;
  logic [3:0]  endereco_n;
  logic [7:0]  linha_n, coluna_n;
  logic        quadro_fim_n;
  logic        apagado, apagado_n;

  // Row 0 lives in the top byte of the pattern word.
  function automatic logic [7:0] byte_linha(input logic [63:0] q, input logic [2:0] i);
    return q[{~i, 3'b000} +: 8];
  endfunction

  // Next-state and next-output logic; outputs are precomputed so the
  // registered linha/coluna already show row 0 in the first VARRE cycle.
  always_comb begin
    state_n      = state;
    quadro_n     = quadro;
    indice_n     = indice;
    contador_n   = contador;
    endereco_n   = endereco;
    linha_n      = '0;
    coluna_n     = '0;
    quadro_fim_n = 1'b0;
    apagado_n    = apagado;
    proxima      = indice + 3'd1;
    case (state)
      BUSCA: begin
        endereco_n = selecao;
        if (habilita) state_n = ESPERA;
      end
      ESPERA: state_n = CAPTURA;
      CAPTURA: begin
        quadro_n   = padrao;
        indice_n   = '0;
        contador_n = '0;
        state_n    = VARRE;
`ifdef TEATRIS_BLANK_EN
        apagado_n  = 1'b1;
`else
        linha_n    = 8'b0000_0001;
        coluna_n   = byte_linha(padrao, 3'd0);
`endif
      end
      VARRE: begin
        if (!habilita) begin
          state_n = BUSCA;
`ifdef TEATRIS_BLANK_EN
        end else if (apagado) begin
          apagado_n = 1'b0;
          linha_n   = 8'b0000_0001 << indice;
          coluna_n  = byte_linha(quadro, indice);
`endif
        end else if (contador != ULTIMO) begin
          contador_n = contador + 16'd1;
          linha_n    = 8'b0000_0001 << indice;
          coluna_n   = byte_linha(quadro, indice);
        end else if (indice == 3'd7) begin
          state_n      = BUSCA;
          quadro_fim_n = 1'b1;
        end else begin
          indice_n   = proxima;
          contador_n = '0;
`ifdef TEATRIS_BLANK_EN
          apagado_n  = 1'b1;
`else
          linha_n    = 8'b0000_0001 << proxima;
          coluna_n   = byte_linha(quadro, proxima);
`endif
        end
      end
      default: state_n = BUSCA;
    endcase
  end

  // State and registered outputs, synchronous reset has top priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= BUSCA;
      endereco   <= '0;
      linha      <= '0;
      coluna     <= '0;
      quadro_fim <= 1'b0;
      quadro     <= '0;
      indice     <= '0;
      contador   <= '0;
      apagado    <= 1'b0;
    end else begin
      state      <= state_n;
      endereco   <= endereco_n;
      linha      <= linha_n;
      coluna     <= coluna_n;
      quadro_fim <= quadro_fim_n;
      quadro     <= quadro_n;
      indice     <= indice_n;
      contador   <= contador_n;
      apagado    <= apagado_n;
    end
  end

endmodule

// File: tb/tb_teatris_varredura_matriz.sv
// Self-checking bench for teatris_varredura_matriz with DIVISOR=4.
// Expected outputs come from a time-since-frame-start model of the scan.
module tb_teatris_varredura_matriz;

  localparam int unsigned D = 4;
`ifdef TEATRIS_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int unsigned P     = D + (BLANK ? 1 : 0);
  localparam int unsigned FRAME = 3 + 8 * P;

  logic        clock = 1'b0;
  logic        reset, habilita;
  logic [3:0]  selecao, endereco;
  logic [63:0] padrao;
  logic [7:0]  linha, coluna;
  logic        quadro_fim;

  logic [63:0] rom [16];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: k = cycles since the current BUSCA cycle began (0 = idle/fetch).
  int unsigned k = 0;
  logic [3:0]  m_end;
  logic [63:0] m_pend, m_buf;
  logic        m_qf;

  teatris_varredura_matriz #(.DIVISOR(D)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .selecao(selecao),
    .endereco(endereco), .padrao(padrao), .linha(linha), .coluna(coluna),
    .quadro_fim(quadro_fim)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data valid one clock after the address.
  always @(posedge clock) padrao <= rom[endereco];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      k = 0; m_end = '0; m_buf = '0; m_qf = 1'b0;
    end else begin
      m_qf = 1'b0;
      if (k == 0) begin
        m_end = selecao;
        if (habilita) k = 1;
      end else if (k == 1) begin
        m_pend = rom[m_end];
        k = 2;
      end else if (k == 2) begin
        m_buf = m_pend;
        k = 3;
      end else if (!habilita) begin
        k = 0;
      end else begin
        k++;
        if (k == FRAME) begin
          k = 0;
          m_qf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] el, ec;
    int unsigned j, r, off;
    el = '0;
    ec = '0;
    if (k >= 3) begin
      j   = k - 3;
      r   = j / P;
      off = j % P;
      if (!(BLANK && off == 0)) begin
        el = 8'(1 << r);
        ec = m_buf[8*(7-r) +: 8];
      end
    end
    check("linha", linha, el);
    check("coluna", coluna, ec);
    check("endereco", endereco, m_end);
    check("quadro_fim", quadro_fim, m_qf);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic wait_qf(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (quadro_fim) found = 1'b1;
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    int t0;
    bit saw;
    bit found;
    for (int i = 0; i < 16; i++) rom[i] = {$urandom, $urandom};
    rom[15] = 64'h08_5C_FE_0F_FF_0F_BF_0F;
    reset = 1'b1; habilita = 1'b0; selecao = 4'd0;
    m_end = '0; m_buf = '0; m_pend = '0; m_qf = 1'b0;
    #2;
    repeat (3) step();
    check("reset_linha", linha, 8'h00);

    // Row sequence with the reference pattern and frame timing.
    selecao = 4'd15; habilita = 1'b1; reset = 1'b0;
    t0 = cyc;
    wait_qf("first_frame_timeout");
    check("first_frame_len", cyc - t0, FRAME);
    t0 = cyc;
    wait_qf("second_frame_timeout");
    check("frame_interval", cyc - t0, FRAME);

    // Selecao change mid-frame only takes effect at the next fetch.
    selecao = 4'd3;
    wait_qf("sel3_frame_timeout");
    repeat (10) step();
    selecao = 4'd7;
    check("endereco_hold", endereco, 4'd3);
    wait_qf("sel7_frame_timeout");
    step();
    check("endereco_next_fetch", endereco, 4'd7);
    m_pend = rom[7];
    step();
    step();
    check("coluna_new_data", coluna, BLANK ? 8'h00 : m_pend[63:56]);

    // Reset mid-scan for three cycles.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (k >= 3 + 2 * P) found = 1'b1;
    end
    check("reach_midscan", found, 1'b1);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_endereco", endereco, 4'd0);
    check("reset_coluna", coluna, 8'h00);
    check("reset_qf", quadro_fim, 1'b0);

    // Drop habilita during row 5.
    selecao = 4'd15;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (k == 3 + 5 * P + 1) found = 1'b1;
    end
    check("reach_row5", found, 1'b1);
    check("row5_lit", linha, 8'h20);
    habilita = 1'b0;
    saw = 1'b0;
    step();
    check("linha_after_drop", linha, 8'h00);
    check("coluna_after_drop", coluna, 8'h00);
    for (int i = 0; i < 6; i++) begin
      selecao = 4'(i + 1);
      step();
      saw = saw | quadro_fim;
    end
    check("no_qf_on_drop", saw, 1'b0);
    selecao = 4'd15;
    habilita = 1'b1;
    repeat (3) step();
    check("restart_row0", linha, BLANK ? 8'h00 : 8'h01);

    // Randomized stretch against the model.
    for (int i = 0; i < 600; i++) begin
      selecao  = 4'($urandom_range(0, 15));
      habilita = ($urandom_range(0, 59) != 0);
      reset    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) rom[$urandom_range(0, 15)] = {$urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
